alu_lane_sequencer: RTL and testbench
=====================================

// Module: alu_lane_sequencer
// PURPOSE
//   Sequences one vector ALU operation (V bits = L lanes of S bits) through the
//   single shared scalar ALU, one lane per clock. Lane results and zero flags
//   are collected into one vector result with per-lane zero/div-by-zero masks.
//   It sits between the vector issue stage (valid/ready) and the scalar ALU.
// PARAMETERS
//   V   192     vector width in bits; must be an integer multiple of S
//   S   32      lane / scalar ALU width in bits
//   L   V/S     localparam: lane count (6 at defaults); lane counter is $clog2(L) bits
// PORTS
//   clk        in   1      clock; all state updates on rising edge
//   rst_n      in   1      asynchronous active-low reset
//   in_valid   in   1      vector op request valid
//   in_ready   out  1      sequencer can accept a request
//   in_a       in   V      operand A; lane i = in_a[i*S +: S]
//   in_b       in   V      operand B; same lane mapping
//   in_op      in   3      ALU select: 0 add, 1 sub, 2 mul, 3 div; 4-7 forwarded unchanged
//   alu_a      out  S      to scalar ALU operand A
//   alu_b      out  S      to scalar ALU operand B
//   alu_sel    out  3      to scalar ALU select
//   alu_c      in   S      scalar ALU result (combinational, same cycle)
//   alu_z      in   1      scalar ALU zero flag (same cycle)
//   out_valid  out  1      vector result valid
//   out_ready  in   1      consumer accepts result
//   out_c      out  V      vector result; lane mapping as in_a
//   out_zmask  out  L      bit i = lane i result is zero
//   out_divz   out  L      bit i = lane i was a division by zero
//   out_allz   out  1      all lanes zero (&out_zmask)
// BEHAVIOUR
//   - States: IDLE, RUN, DONE. Reset -> IDLE.
//   - Reset (rst_n=0, async): state IDLE, lane counter 0, in_ready=0, out_valid=0,
//     out_c/out_zmask/out_divz/out_allz=0, alu_a/alu_b/alu_sel=0. in_ready goes 1
//     on the first clock edge after rst_n deasserts.
//   - Reset mid-operation aborts: latched operands and partial results are
//     discarded; no out_valid is produced for the aborted op.
//   - IDLE: in_ready=1. On in_valid&&in_ready: latch in_a, in_b, in_op; clear
//     result, zmask, divz; counter=0; -> RUN. in_ready=0 in RUN and DONE.
//   - RUN: alu_a/alu_b = latched lane[counter], alu_sel = latched op. At the edge
//     capture alu_c into result lane[counter], alu_z into zmask[counter].
//     counter==L-1 -> DONE, counter cleared; else counter+1.
//   - Div-by-zero: op==3 and B lane==0 -> store all-ones (S'('1)) for that lane,
//     zmask bit 0, divz bit 1; the ALU output for that cycle is ignored.
//   - DONE: out_valid=1; out_c/out_zmask/out_divz/out_allz registered and held
//     stable until out_valid&&out_ready, then -> IDLE (out_valid=0 next cycle).
//   - Outside RUN: alu_a, alu_b, alu_sel driven 0.
//   - Latency: accept at edge t -> out_valid high after edge t+L (L RUN cycles);
//     with out_ready held 1, next accept possible L+2 cycles after previous.
//   - Arithmetic is done in the ALU: S-bit wraparound, mul keeps low S bits, div
//     unsigned truncating. The sequencer never widens or sign-extends.
//   - Back-pressure: out_ready low in DONE holds all outputs; in_valid is ignored.
// TESTING
//   1 reset: rst_n=0 mid-RUN at lane 3 -> in_ready=0, out_valid=0, alu_* =0;
//     release -> in_ready=1, next op completes normally with no stale lanes
//   2 add op=0, A lanes {1,2,3,4,5,6}, B lanes {10,20,30,40,50,60} ->
//     out_c {11,22,33,44,55,66}, out_zmask=0, out_valid exactly L cycles after accept
//   3 sub op=1, A=B=all lanes 7 -> out_c all 0, out_zmask=6'b111111, out_allz=1;
//     A lane0=0, B lane0=1 -> lane0=32'hFFFFFFFF (wrap), zmask[0]=0
//   4 div op=3, A lanes 100, B lanes {5,0,3,0,1,100} -> out_c {20,FFFFFFFF,33,
//     FFFFFFFF,100,1}, out_divz=6'b001010, out_zmask=0
//   5 back-pressure: out_ready=0 for 5 cycles in DONE with in_valid=1 ->
//     outputs stable, in_ready=0, no new op latched; out_ready=1 -> IDLE next cycle
//   6 mul op=2, lane 32'h10000 * 32'h10000 -> 0 (low S bits), zmask bit set;
//     check alu_sel=2 and alu_a/alu_b step lane 0..5 in order during RUN

Source files
------------

// File: rtl/alu_lane_sequencer.sv
// rtl/alu_lane_sequencer.sv - sequences one vector ALU op lane-by-lane through a shared scalar ALU
//
// Ports:
//   clk, rst_n            clock, asynchronous active-low reset
//   in_valid/in_ready     vector request handshake; in_a/in_b (V bits), in_op (3 bits)
//   alu_a/alu_b/alu_sel   registered drive to the scalar ALU (zero outside RUN)
//   alu_c/alu_z           scalar ALU result and zero flag, same cycle
//   out_valid/out_ready   vector result handshake
//   out_c                 vector result (lane i = out_c[i*S +: S])
//   out_zmask/out_divz    per-lane zero and divide-by-zero masks
//   out_allz              all lanes zero
module alu_lane_sequencer #(
  parameter int V = 192,
  parameter int S = 32,
  localparam int L = V / S,
  localparam int CW = (L > 1) ? $clog2(L) : 1
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [V-1:0] in_a,
  input  logic [V-1:0] in_b,
  input  logic [2:0]   in_op,
  output logic [S-1:0] alu_a,
  output logic [S-1:0] alu_b,
  output logic [2:0]   alu_sel,
  input  logic [S-1:0] alu_c,
  input  logic         alu_z,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [V-1:0] out_c,
  output logic [L-1:0] out_zmask,
  output logic [L-1:0] out_divz,
  output logic         out_allz
);

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  state_t        state;
  logic [CW-1:0] cnt;
  // Operand shift registers: the lane to present next sits in the low S bits.
  logic [V-1:0]  a_sh;
  logic [V-1:0]  b_sh;

  logic [S-1:0]  lane_res;
  logic          lane_z;
  logic          lane_divz;
  logic [L-1:0]  zmask_next;

  // alu_b/alu_sel are the registered copies of the current lane, so the
  // divide-by-zero override can be decided from them directly.
  always_comb begin
    lane_divz  = (alu_sel == 3'd3) && (alu_b == '0);
    lane_res   = lane_divz ? {S{1'b1}} : alu_c;
    lane_z     = lane_divz ? 1'b0 : alu_z;
    zmask_next = {lane_z, out_zmask[L-1:1]};
  end

  // Results shift in from the top lane; after L captures lane 0 is at the bottom.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      cnt       <= '0;
      a_sh      <= '0;
      b_sh      <= '0;
      in_ready  <= 1'b0;
      out_valid <= 1'b0;
      out_c     <= '0;
      out_zmask <= '0;
      out_divz  <= '0;
      out_allz  <= 1'b0;
      alu_a     <= '0;
      alu_b     <= '0;
      alu_sel   <= '0;
    end else begin
      case (state)
        IDLE: begin
          in_ready <= 1'b1;
          if (in_valid && in_ready) begin
            in_ready  <= 1'b0;
            alu_a     <= in_a[S-1:0];
            alu_b     <= in_b[S-1:0];
            alu_sel   <= in_op;
            a_sh      <= in_a >> S;
            b_sh      <= in_b >> S;
            out_c     <= '0;
            out_zmask <= '0;
            out_divz  <= '0;
            out_allz  <= 1'b0;
            cnt       <= '0;
            state     <= RUN;
          end
        end
        RUN: begin
          out_c     <= {lane_res, out_c[V-1:S]};
          out_zmask <= zmask_next;
          out_divz  <= {lane_divz, out_divz[L-1:1]};
          if (cnt == CW'(L - 1)) begin
            cnt       <= '0;
            out_allz  <= &zmask_next;
            out_valid <= 1'b1;
            alu_a     <= '0;
            alu_b     <= '0;
            alu_sel   <= '0;
            state     <= DONE;
          end else begin
            cnt   <= cnt + 1'b1;
            alu_a <= a_sh[S-1:0];
            alu_b <= b_sh[S-1:0];
            a_sh  <= a_sh >> S;
            b_sh  <= b_sh >> S;
          end
        end
        DONE: begin
          if (out_ready) begin
            out_valid <= 1'b0;
            in_ready  <= 1'b1;
            state     <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_alu_lane_sequencer.sv
// tb/tb_alu_lane_sequencer.sv - self-checking bench for alu_lane_sequencer
module tb_alu_lane_sequencer;
  localparam int V = 192;
  localparam int S = 32;
  localparam int L = V / S;

  logic         clk = 1'b0;
  logic         rst_n;
  logic         in_valid;
  logic         in_ready;
  logic [V-1:0] in_a;
  logic [V-1:0] in_b;
  logic [2:0]   in_op;
  logic [S-1:0] alu_a;
  logic [S-1:0] alu_b;
  logic [2:0]   alu_sel;
  logic [S-1:0] alu_c;
  logic         alu_z;
  logic         out_valid;
  logic         out_ready;
  logic [V-1:0] out_c;
  logic [L-1:0] out_zmask;
  logic [L-1:0] out_divz;
  logic         out_allz;

  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  alu_lane_sequencer #(.V(V), .S(S)) dut (
    .clk(clk), .rst_n(rst_n),
    .in_valid(in_valid), .in_ready(in_ready),
    .in_a(in_a), .in_b(in_b), .in_op(in_op),
    .alu_a(alu_a), .alu_b(alu_b), .alu_sel(alu_sel),
    .alu_c(alu_c), .alu_z(alu_z),
    .out_valid(out_valid), .out_ready(out_ready),
    .out_c(out_c), .out_zmask(out_zmask), .out_divz(out_divz), .out_allz(out_allz)
  );

  // Scalar ALU; on divide by zero it returns a misleading 0 / zero flag that
  // the sequencer must ignore.
  always_comb begin
    alu_c = '0;
    alu_z = 1'b0;
    case (alu_sel)
      3'd0: alu_c = alu_a + alu_b;
      3'd1: alu_c = alu_a - alu_b;
      3'd2: alu_c = alu_a * alu_b;
      3'd3: alu_c = (alu_b == '0) ? '0 : alu_a / alu_b;
      default: alu_c = alu_a ^ alu_b;
    endcase
    alu_z = (alu_c == '0);
  end

  task automatic check(input string tag, input logic [V-1:0] obs, input logic [V-1:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  function automatic logic [V-1:0] pack6(input logic [S-1:0] x0, x1, x2, x3, x4, x5);
    return {x5, x4, x3, x2, x1, x0};
  endfunction

  // Reference: per-lane arithmetic straight from the operation definitions.
  function automatic void model(input logic [V-1:0] a, b, input logic [2:0] op,
                                output logic [V-1:0] c, output logic [L-1:0] zm, dz);
    logic [S-1:0] x, y, r;
    c = '0; zm = '0; dz = '0;
    for (int i = 0; i < L; i++) begin
      x = a[i*S +: S];
      y = b[i*S +: S];
      dz[i] = (op == 3'd3) && (y == '0);
      case (op)
        3'd0: r = x + y;
        3'd1: r = x - y;
        3'd2: r = x * y;
        3'd3: r = (y == '0) ? {S{1'b1}} : x / y;
        default: r = x ^ y;
      endcase
      c[i*S +: S] = r;
      zm[i] = !dz[i] && (r == '0);
    end
  endfunction

  task automatic run_op(input logic [V-1:0] a, b, input logic [2:0] op, input int stall);
    logic [V-1:0] ec;
    logic [L-1:0] ez, ed;
    int n;
    model(a, b, op, ec, ez, ed);
    n = 0;
    while (!in_ready && n < 20) begin
      @(negedge clk);
      n++;
    end
    check("in_ready_before_accept", in_ready, 1);
    in_a = a; in_b = b; in_op = op; in_valid = 1'b1; out_ready = 1'b0;
    @(posedge clk);
    @(negedge clk);
    in_valid = 1'b0;
    in_a = {$urandom, $urandom, $urandom, $urandom, $urandom, $urandom};
    in_b = {$urandom, $urandom, $urandom, $urandom, $urandom, $urandom};
    for (int i = 0; i < L; i++) begin
      check($sformatf("run_alu_a_lane%0d", i), alu_a, a[i*S +: S]);
      check($sformatf("run_alu_b_lane%0d", i), alu_b, b[i*S +: S]);
      check("run_alu_sel", alu_sel, op);
      check("run_out_valid", out_valid, 0);
      check("run_in_ready", in_ready, 0);
      @(negedge clk);
    end
    check("done_out_valid", out_valid, 1);
    check("done_alu_a", alu_a, 0);
    check("done_alu_sel", alu_sel, 0);
    check("done_in_ready", in_ready, 0);
    check("out_c", out_c, ec);
    check("out_zmask", out_zmask, ez);
    check("out_divz", out_divz, ed);
    check("out_allz", out_allz, &ez);
    in_valid = 1'b1;
    for (int k = 0; k < stall; k++) begin
      in_a = {$urandom, $urandom, $urandom, $urandom, $urandom, $urandom};
      @(negedge clk);
      check("stall_out_valid", out_valid, 1);
      check("stall_in_ready", in_ready, 0);
      check("stall_out_c", out_c, ec);
      check("stall_zmask", out_zmask, ez);
      check("stall_divz", out_divz, ed);
      check("stall_alu_sel", alu_sel, 0);
    end
    in_valid = 1'b0;
    out_ready = 1'b1;
    @(negedge clk);
    out_ready = 1'b0;
    check("post_out_valid", out_valid, 0);
    check("post_in_ready", in_ready, 1);
  endtask

  logic [V-1:0] ra, rb;
  logic [S-1:0] ones;

  initial begin
    ones = '1;
    rst_n = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
    in_a = '0; in_b = '0; in_op = '0;
    repeat (2) @(negedge clk);
    check("rst_in_ready", in_ready, 0);
    check("rst_out_valid", out_valid, 0);
    check("rst_out_c", out_c, 0);
    check("rst_alu_a", alu_a, 0);
    rst_n = 1'b1;
    check("rst_release_in_ready", in_ready, 0);
    @(negedge clk);
    check("first_edge_in_ready", in_ready, 1);

    // Abort mid-RUN at lane 3.
    in_a = pack6(9, 9, 9, 9, 9, 9); in_b = pack6(1, 1, 1, 1, 1, 1); in_op = 3'd0;
    in_valid = 1'b1;
    @(posedge clk);
    @(negedge clk);
    in_valid = 1'b0;
    repeat (3) @(negedge clk);
    check("abort_lane3_alu_a", alu_a, 9);
    rst_n = 1'b0;
    #1;
    check("abort_in_ready", in_ready, 0);
    check("abort_out_valid", out_valid, 0);
    check("abort_alu_a", alu_a, 0);
    check("abort_alu_b", alu_b, 0);
    check("abort_alu_sel", alu_sel, 0);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    check("abort_release_in_ready", in_ready, 1);
    check("abort_release_out_valid", out_valid, 0);

    run_op(pack6(1, 2, 3, 4, 5, 6), pack6(10, 20, 30, 40, 50, 60), 3'd0, 0);
    run_op(pack6(7, 7, 7, 7, 7, 7), pack6(7, 7, 7, 7, 7, 7), 3'd1, 0);
    run_op(pack6(0, 7, 7, 7, 7, 7), pack6(1, 7, 7, 7, 7, 7), 3'd1, 0);
    run_op(pack6(100, 100, 100, 100, 100, 100), pack6(5, 0, 3, 0, 1, 100), 3'd3, 5);
    run_op(pack6(32'h10000, 3, 32'hFFFFFFFF, 0, 32'h80000000, 5),
           pack6(32'h10000, 4, 32'hFFFFFFFF, 9, 2, 0), 3'd2, 0);

    for (int t = 0; t < 24; t++) begin
      for (int i = 0; i < L; i++) begin
        ra[i*S +: S] = $urandom;
        case ($urandom_range(0, 3))
          0: rb[i*S +: S] = '0;
          1: rb[i*S +: S] = ra[i*S +: S];
          2: rb[i*S +: S] = $urandom_range(1, 7);
          default: rb[i*S +: S] = $urandom;
        endcase
      end
      run_op(ra, rb, 3'($urandom_range(0, 7)), $urandom_range(0, 2));
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
